// File: rtl/sar_conv_sched_if.sv
// sar_conv_sched_if: requester/SAR handshake bundle for sar_conv_sched
interface sar_conv_sched_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic       cnvst;
    logic       eoc;
    logic [7:0] sar_in;
    logic [7:0] result;
    logic [1:0] result_id;
    logic       result_valid;
    logic       result_ack;
    logic       timeout_err;
    modport master (
        output req, eoc, sar_in, result_ack,
        input  grant, cnvst, result, result_id, result_valid, timeout_err
    );
    modport slave (
        input  req, eoc, sar_in, result_ack,
        output grant, cnvst, result, result_id, result_valid, timeout_err
    );
endinterface

// File: rtl/sar_conv_sched.sv
// sar_conv_sched: round-robin scheduler sharing one SAR converter among 4 requesters.
// Define SAR_AVG4_EN to average 4 conversions per grant.
module sar_conv_sched #(
    parameter int TIMEOUT = 64,
    parameter int SETTLE  = 2
) (
    input logic            clk,
    input logic            rst,
    sar_conv_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARB, START, CONV, GAP, DONE} state_t;
    state_t     state;
    logic [1:0] ptr;
    logic [1:0] sel;
    logic [7:0] tcnt;
    logic [3:0] gcnt;
`ifdef SAR_AVG4_EN
    logic [9:0] acc;
    logic [9:0] acc_nx;
    logic [1:0] nconv;
    assign acc_nx = acc + 10'(bus.sar_in);
`endif
    // first requester at or after ptr, searched in wrapping order
    always_comb begin
        sel = ptr;
        for (int i = 3; i >= 0; i--)
            if (bus.req[ptr + 2'(i)]) sel = ptr + 2'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= '0;
            tcnt             <= '0;
            gcnt             <= '0;
            bus.grant        <= '0;
            bus.cnvst        <= 1'b0;
            bus.result       <= '0;
            bus.result_id    <= '0;
            bus.result_valid <= 1'b0;
            bus.timeout_err  <= 1'b0;
`ifdef SAR_AVG4_EN
            acc              <= '0;
            nconv            <= '0;
`endif
        end else begin
            case (state)
                IDLE: state <= |bus.req ? ARB : IDLE;
                ARB: begin
                    if (|bus.req) begin
                        bus.grant     <= 4'b1 << sel;
                        bus.result_id <= sel;
                        bus.cnvst     <= 1'b1;
                        state         <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    bus.cnvst <= 1'b0;
                    tcnt      <= '0;
                    state     <= CONV;
                end
                CONV: begin
                    if (bus.eoc) begin
`ifdef SAR_AVG4_EN
                        acc <= acc_nx;
                        if (nconv == 2'd3) begin
                            bus.result       <= acc_nx[9:2];
                            bus.timeout_err  <= 1'b0;
                            bus.result_valid <= 1'b1;
                            state            <= DONE;
                        end else begin
                            nconv <= nconv + 2'd1;
                            gcnt  <= '0;
                            state <= GAP;
                        end
`else
                        bus.result       <= bus.sar_in;
                        bus.timeout_err  <= 1'b0;
                        bus.result_valid <= 1'b1;
                        state            <= DONE;
`endif
                    end else if (tcnt == 8'(TIMEOUT - 1)) begin
                        bus.result       <= '0;
                        bus.timeout_err  <= 1'b1;
                        bus.result_valid <= 1'b1;
                        state            <= DONE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                DONE: begin
                    if (bus.result_ack) begin
                        bus.result_valid <= 1'b0;
                        bus.grant        <= '0;
                        ptr              <= bus.result_id + 2'd1;
                        gcnt             <= '0;
                        state            <= GAP;
`ifdef SAR_AVG4_EN
                        acc              <= '0;
                        nconv            <= '0;
`endif
                    end
                end
                GAP: begin
                    if (gcnt == 4'(SETTLE - 1)) begin
                        gcnt <= '0;
`ifdef SAR_AVG4_EN
                        // a nonzero sample count means the averaging burst is still running
                        bus.cnvst <= nconv != 2'd0;
                        state     <= nconv != 2'd0 ? START : IDLE;
`else
                        state <= IDLE;
`endif
                    end else begin
                        gcnt <= gcnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_conv_sched.sv
// tb_sar_conv_sched: randomized bench for sar_conv_sched against a transaction-level model
module tb_sar_conv_sched;
    localparam int TO = 64;
    localparam int ST = 2;
`ifdef SAR_AVG4_EN
    localparam int NC = 4;
    localparam int EXP_FIRST = 11;
`else
    localparam int NC = 1;
    localparam int EXP_FIRST = 8'hA5;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    sar_conv_sched_if bus();
    sar_conv_sched #(.TIMEOUT(TO), .SETTLE(ST)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask
    // stimulus controls shared between the driver and the monitor
    bit         rand_req = 0;
    bit         auto_clr = 1;
    bit         spur_en  = 0;
    int         ack_mode = 1;
    logic [3:0] clr_mask = '0;
    int         eoc_cyc  = -1;
    logic [7:0] eoc_data = '0;
    int         pend_end = -1;
    int         dq_d[$];
    logic [7:0] dq_v[$];
    // model state
    logic [1:0] m_ptr = '0;
    int         exp_idx = 0;
    bit         owned = 0;
    int         conv_n = 0;
    int         sum = 0;
    logic [7:0] exp_res = '0;
    bit         exp_err = 0;
    int         exp_valid_cyc = -1;
    int         exp_next = -1;
    int         last_cnvst = -1000;
    int         last_ack = -1000;
    int         services = 0;
    logic [3:0] req_q = '0;
    bit         rst_q = 0;
    bit         valid_q = 0;
    bit         ack_q = 0;
    int         d;
    logic [7:0] v;
    function automatic logic [1:0] rr(logic [3:0] r, logic [1:0] p);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] j;
            j = p + 2'(i);
            if (r[j]) return j;
        end
        return p;
    endfunction
    always @(negedge clk) begin
        if (rst) begin
            owned = 0; m_ptr = '0; conv_n = 0; sum = 0;
            exp_valid_cyc = -1; exp_next = -1;
            last_cnvst = -1000; last_ack = -1000; pend_end = -1;
        end else begin
            if (rst_q) begin
                chk("rst_grant", int'(bus.grant), 0);
                chk("rst_cnvst", int'(bus.cnvst), 0);
                chk("rst_result", int'(bus.result), 0);
                chk("rst_result_id", int'(bus.result_id), 0);
                chk("rst_valid", int'(bus.result_valid), 0);
                chk("rst_timeout_err", int'(bus.timeout_err), 0);
            end
            if (owned && (bus.cnvst || cyc == exp_next))
                chk("restart_cnvst", bus.cnvst ? cyc : -1, exp_next);
            if (bus.cnvst) begin
                if (!owned) begin
                    exp_idx = int'(rr(req_q, m_ptr));
                    chk("cnvst_spacing", int'(cyc - last_cnvst >= ST + 3 && cyc - last_ack >= ST + 3), 1);
                    chk("grant_pick", int'(bus.grant), 1 << exp_idx);
                    owned = 1; conv_n = 0; sum = 0;
                end
                if (dq_d.size() > 0) begin
                    d = dq_d.pop_front();
                    v = dq_v.pop_front();
                end else begin
                    d = ($urandom % 6 == 0) ? TO - 2 + int'($urandom % 7) : 1 + int'($urandom % 10);
                    v = 8'($urandom);
                end
                conv_n++;
                eoc_cyc = cyc + d;
                eoc_data = v;
                pend_end = cyc + (d <= TO ? d : TO);
                exp_next = -1;
                exp_valid_cyc = -1;
                if (d > TO) begin
                    exp_res = '0; exp_err = 1; exp_valid_cyc = cyc + TO + 1;
                end else begin
                    sum += int'(v);
                    if (conv_n == NC) begin
                        exp_res = 8'(sum / NC); exp_err = 0; exp_valid_cyc = cyc + d + 1;
                    end else begin
                        exp_next = cyc + d + ST + 1;
                    end
                end
                last_cnvst = cyc;
            end
            chk("grant", int'(bus.grant), owned ? 1 << exp_idx : 0);
            if ((bus.result_valid && !valid_q) || cyc == exp_valid_cyc)
                chk("valid_rise", (bus.result_valid && !valid_q) ? cyc : -1, exp_valid_cyc);
            if (valid_q && !rst_q) chk("valid_hold", int'(bus.result_valid), int'(!ack_q));
            if (bus.result_valid) begin
                chk("result", int'(bus.result), int'(exp_res));
                chk("result_id", int'(bus.result_id), exp_idx);
                chk("timeout_err", int'(bus.timeout_err), int'(exp_err));
                if (bus.result_ack) begin
                    owned = 0;
                    m_ptr = 2'(exp_idx + 1);
                    last_ack = cyc;
                    services++;
                    if (auto_clr) clr_mask |= 4'(1 << exp_idx);
                    exp_valid_cyc = -1;
                    exp_next = -1;
                end
            end
        end
        req_q = bus.req;
        rst_q = rst;
        valid_q = bus.result_valid;
        ack_q = bus.result_ack;
    end
    task automatic step();
        @(posedge clk);
        #1;
        bus.req = bus.req & ~clr_mask;
        clr_mask = '0;
        if (rand_req)
            for (int i = 0; i < 4; i++) if ($urandom % 12 == 0) bus.req[i] = 1'b1;
        bus.eoc = (cyc == eoc_cyc) || (spur_en && cyc > pend_end && $urandom % 10 == 0);
        bus.sar_in = (cyc == eoc_cyc) ? eoc_data : 8'($urandom);
        bus.result_ack = ack_mode == 0 ? 1'b0 : ack_mode == 1 ? 1'b1 : ($urandom % 3 == 0);
    endtask
    task automatic wait_cnvst(int lim, output int c);
        c = -1;
        for (int k = 0; k < lim; k++) begin
            step();
            if (bus.cnvst) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("wait_cnvst_bound", 0, 1);
    endtask
    task automatic wait_valid(int lim, output int c);
        c = -1;
        for (int k = 0; k < lim; k++) begin
            step();
            if (bus.result_valid) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("wait_valid_bound", 0, 1);
    endtask
    int r, c, vc;
    logic [7:0] hold_res;
    int g[5];
    int order[5] = '{1, 2, 4, 8, 1};
    initial begin
        bus.req = '0; bus.eoc = 1'b0; bus.sar_in = '0; bus.result_ack = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        // single requester, eoc 5 cycles after cnvst
`ifdef SAR_AVG4_EN
        dq_d = '{5, 5, 5, 5}; dq_v = '{8'd10, 8'd11, 8'd12, 8'd14};
`else
        dq_d = '{5}; dq_v = '{8'hA5};
`endif
        bus.req = 4'b0001;
        r = cyc;
        wait_cnvst(20, c);
        chk("t1_req_to_cnvst", c - r, 2);
        wait_valid(200, vc);
        chk("t1_grant", int'(bus.grant), 1);
        chk("t1_result", int'(bus.result), EXP_FIRST);
        chk("t1_id", int'(bus.result_id), 0);
        chk("t1_err", int'(bus.timeout_err), 0);
        // eoc never arrives within the window
        dq_d.push_back(TO + 3); dq_v.push_back(8'h5A);
        bus.req = 4'b0100;
        wait_cnvst(40, c);
        wait_valid(200, vc);
        chk("t2_timeout_latency", vc - c, TO + 1);
        chk("t2_result", int'(bus.result), 0);
        chk("t2_err", int'(bus.timeout_err), 1);
        chk("t2_id", int'(bus.result_id), 2);
        // ack withheld for 10 cycles; 1001 from ptr 3 must pick requester 3
        ack_mode = 0;
        bus.req = 4'b1001;
        wait_valid(300, vc);
        chk("t3_grant", int'(bus.grant), 8);
        hold_res = bus.result;
        repeat (10) begin
            step();
            chk("t3_hold_result", int'(bus.result), int'(hold_res));
            chk("t3_hold_valid", int'(bus.result_valid), 1);
        end
        ack_mode = 1;
        step();
        ack_mode = 0;
        repeat (ST + 2) begin
            step();
            chk("t3_no_cnvst", int'(bus.cnvst), 0);
        end
        ack_mode = 1;
        wait_valid(300, vc);
        chk("t3_next_grant", int'(bus.grant), 1);
        step();
        // all four held: expect rotation starting from requester 1 (ptr=1 now)
        auto_clr = 0;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_valid(400, vc);
            g[k] = int'(bus.grant);
            step();
        end
        bus.req = 4'b0000;
        auto_clr = 1;
        for (int k = 0; k < 5; k++) chk("t4_order", g[k], order[(k + 1) % 4]);
        repeat (ST + 2) step();
        // reset in CONV discards the conversion and ptr
        dq_d.push_back(10); dq_v.push_back(8'h77);
        bus.req = 4'b0100;
        wait_cnvst(40, c);
        step();
        step();
        rst = 1'b1;
        bus.req = 4'b0000;
        step();
        rst = 1'b0;
        chk("t5_zero", int'({bus.grant, bus.cnvst, bus.result, bus.result_id, bus.result_valid, bus.timeout_err}), 0);
        repeat (12) step();
        chk("t5_late_eoc_ignored", int'(bus.result_valid), 0);
        bus.req = 4'b1001;
        wait_valid(300, vc);
        chk("t5_ptr_reset", int'(bus.grant), 1);
        // random traffic
        rand_req = 1; spur_en = 1; ack_mode = 2;
        repeat (6000) step();
        rand_req = 0;
        for (int k = 0; k < 4000 && (bus.req != 0 || owned); k++) step();
        chk("drain", int'(bus.req != 0 || owned), 0);
        chk("services_enough", int'(services > 30), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
